// File: rtl/arith_pkg.sv
// Shared definitions for the sequential arithmetic examples (multiplier and divider).
package arith_pkg;

  // Default widths shared with the 4-bit multiplier: product width feeds the divider dividend.
  localparam int unsigned MUL_AW = 4;
  localparam int unsigned MUL_PW = 8;

  // FSM encodings used by the sequential arithmetic blocks.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } arith_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift one dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step #(
  parameter int unsigned VW = 4
) (
  input  logic [VW:0]   pr_in,
  input  logic          bit_in,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   pr_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW:0]   diff;

  // The top partial-remainder bit is carried into the compare instead of being dropped. It is
  // only ever set when the divisor is 0, and then the step outcome is identical either way.
  always_comb begin
    shifted = {pr_in, bit_in};
    q_bit   = (shifted >= {2'b00, divisor});
    // Result of a successful subtract is below the divisor, so VW+1 bits are enough.
    diff    = shifted[VW:0] - {1'b0, divisor};
    pr_out  = q_bit ? diff : shifted[VW:0];
  end

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Optional feature macro: DIV_ZERO_FLAG_EN adds the div_zero output and a fast path that
// finishes a divide-by-zero in the cycle after acceptance.
module divider_seq
  import arith_pkg::*;
#(
  parameter int unsigned DW = MUL_PW,
  parameter int unsigned VW = MUL_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic          div_zero
`endif
);

  localparam int unsigned CW = $clog2(DW + 1);

  arith_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [DW-1:0] work_q, work_d;
  logic [VW:0]   pr_q, pr_d;
  logic [VW-1:0] dvs_q, dvs_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
`ifdef DIV_ZERO_FLAG_EN
  logic          dz_q, dz_d;
`endif

  logic [VW:0]   step_pr;
  logic          step_q;

  div_step #(
    .VW(VW)
  ) u_step (
    .pr_in  (pr_q),
    .bit_in (work_q[DW-1]),
    .divisor(dvs_q),
    .pr_out (step_pr),
    .q_bit  (step_q)
  );

  // Next-state: accept in IDLE/DONE, iterate in RUN, capture results on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    pr_d    = pr_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_FLAG_EN
    dz_d    = dz_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          work_d  = dividend;
          pr_d    = '0;
          dvs_d   = divisor;
`ifdef DIV_ZERO_FLAG_EN
          dz_d    = 1'b0;
          // Divide-by-zero bypasses the iterations with the same forced result they produce.
          if (divisor == '0) begin
            state_d = S_DONE;
            dz_d    = 1'b1;
            work_d  = '1;
            pr_d    = {1'b0, dividend[VW-1:0]};
            quo_d   = '1;
            rem_d   = dividend[VW-1:0];
          end
`endif
        end
      end
      S_RUN: begin
        pr_d   = step_pr;
        work_d = {work_q[DW-2:0], step_q};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_d == CW'(DW)) begin
          state_d = S_DONE;
          quo_d   = work_d;
          rem_d   = step_pr[VW-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      pr_q    <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      pr_q    <= pr_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
`ifdef DIV_ZERO_FLAG_EN
      dz_q    <= dz_d;
`endif
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef DIV_ZERO_FLAG_EN
  assign div_zero  = dz_q;
`endif

endmodule

// File: tb/tb_divider_seq.sv
// Self-checking bench for divider_seq: directed vector table plus handshake corner sequences.
module tb_divider_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
`ifdef DIV_ZERO_FLAG_EN
  logic       div_zero;
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 9;
`endif

  int checks = 0;
  int errors = 0;

  divider_seq #(
    .DW(8),
    .VW(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Called at a negedge; edges counts rising edges since (and including) the accepting one.
  task automatic wait_done(input int start_edges, output int edges);
    edges = start_edges;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  // Issue one operation, scramble the operands after acceptance, return at the done cycle.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = ~a;
    divisor  = b + 4'd3;
    wait_done(1, lat);
  endtask

  vec_t vecs[9];
  int   lat;
  int   dones;

  initial begin
    vecs[0] = '{dvd: 8'd225, dvs: 4'd15, q: 8'd15,  r: 4'd0,  lat: 9};
    vecs[1] = '{dvd: 8'd100, dvs: 4'd10, q: 8'd10,  r: 4'd0,  lat: 9};
    vecs[2] = '{dvd: 8'd9,   dvs: 4'd1,  q: 8'd9,   r: 4'd0,  lat: 9};
    vecs[3] = '{dvd: 8'd14,  dvs: 4'd2,  q: 8'd7,   r: 4'd0,  lat: 9};
    vecs[4] = '{dvd: 8'd255, dvs: 4'd7,  q: 8'd36,  r: 4'd3,  lat: 9};
    vecs[5] = '{dvd: 8'd5,   dvs: 4'd9,  q: 8'd0,   r: 4'd5,  lat: 9};
    vecs[6] = '{dvd: 8'd0,   dvs: 4'd5,  q: 8'd0,   r: 4'd0,  lat: 9};
    vecs[7] = '{dvd: 8'd255, dvs: 4'd1,  q: 8'd255, r: 4'd0,  lat: 9};
    vecs[8] = '{dvd: 8'd10,  dvs: 4'd0,  q: 8'd255, r: 4'd10, lat: DZ_LAT};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 4'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
`ifdef DIV_ZERO_FLAG_EN
    check("reset_div_zero", 32'(div_zero), 32'd0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].dvd, vecs[i].dvs, lat);
      check($sformatf("vec%0d_done", i), 32'(done), 32'd1);
      check($sformatf("vec%0d_busy", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
`ifdef DIV_ZERO_FLAG_EN
      check($sformatf("vec%0d_div_zero", i), 32'(div_zero), 32'(vecs[i].dvs == 4'd0));
`endif
      @(negedge clk);
      check($sformatf("vec%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start during RUN is ignored: 255/7 keeps running, 50/5 never takes effect.
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd7;
    start    = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    dividend = 8'd50;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    lat++;
    @(negedge clk);
    start = 1'b0;
    check("ignore_busy", 32'(busy), 32'd1);
    check("ignore_done", 32'(done), 32'd0);
    wait_done(lat, lat);
    check("ignore_quotient", 32'(quotient), 32'd36);
    check("ignore_remainder", 32'(remainder), 32'd3);
    check("ignore_latency", 32'(lat), 32'd9);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("ignore_no_second_done", 32'(dones), 32'd0);

    // Back-to-back: start stays high, second op accepted in the DONE cycle.
    @(negedge clk);
    dividend = 8'd200;
    divisor  = 4'd13;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dividend = 8'd77;
    divisor  = 4'd4;
    wait_done(1, lat);
    check("b2b_first_done", 32'(done), 32'd1);
    check("b2b_first_quotient", 32'(quotient), 32'd15);
    check("b2b_first_remainder", 32'(remainder), 32'd5);
    check("b2b_first_latency", 32'(lat), 32'd9);
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'hff;
    divisor  = 4'd0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_held_quotient", 32'(quotient), 32'd15);
    wait_done(1, lat);
    check("b2b_second_done", 32'(done), 32'd1);
    check("b2b_second_quotient", 32'(quotient), 32'd19);
    check("b2b_second_remainder", 32'(remainder), 32'd1);
    check("b2b_second_latency", 32'(lat), 32'd9);

    // Asynchronous reset in the middle of 255/3.
    @(negedge clk);
    dividend = 8'd255;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);
    do_op(8'd30, 4'd4, lat);
    check("midrst_next_quotient", 32'(quotient), 32'd7);
    check("midrst_next_remainder", 32'(remainder), 32'd2);
    check("midrst_next_latency", 32'(lat), 32'd9);

    // Multiplier round-trip: (a*b)/b == a, remainder 0.
    for (int a = 1; a <= 15; a++) begin
      for (int b = 1; b <= 15; b++) begin
        do_op(8'(a * b), 4'(b), lat);
        check($sformatf("sweep_q_%0dx%0d", a, b), 32'(quotient), 32'(a));
        check($sformatf("sweep_r_%0dx%0d", a, b), 32'(remainder), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
